// File: rtl/uart_pkg.sv
// Shared types for the UART frame parser: parser states, error causes and FIFO entry layout.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHK     = 2'd3
   } parse_state_t;

   typedef enum logic [1:0] {
      ERR_BAD_LEN  = 2'd0,
      ERR_BAD_CHK  = 2'd1,
      ERR_OVERFLOW = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_code_t;

   // Odd so the autobaud receiver upstream can time the start bit against bit 0.
   localparam logic [7:0] SYNC_DEFAULT = 8'h55;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } entry_t;

endpackage

// File: rtl/uart_commit_fifo.sv
// Payload FIFO with a speculative write pointer that is either committed or rewound per frame.
module uart_commit_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  entry_t     wr_entry,
   input  logic       commit,
   input  logic       rewind,
   output logic       m_valid,
   output logic [7:0] m_data,
   output logic       m_last,
   input  logic       m_ready,
   output logic       full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] commit_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] rd_next;
   logic        pop;
   entry_t      mem [DEPTH];
   entry_t      head;

   // The reader only ever sees committed entries, so speculative data stays hidden.
   assign m_valid = (rd_ptr != commit_ptr);
   assign pop     = m_valid & m_ready;
   assign rd_next = rd_ptr + {{AW{1'b0}}, pop};
   assign full    = ((wr_ptr - rd_next) == DEPTH_P);
   assign head    = mem[rd_ptr[AW-1:0]];
   assign m_data  = head.data;
   assign m_last  = head.last;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
      end else begin
         rd_ptr <= rd_next;
         if (rewind)
            wr_ptr <= commit_ptr;
         else if (wr_en)
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (commit)
            commit_ptr <= wr_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= wr_entry;
   end

endmodule

// File: rtl/uart_frame_parser.sv
// Deframes SYNC/LEN/payload/CHK byte streams and releases payload only after the checksum verifies.
module uart_frame_parser
   import uart_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
   parameter int         MAX_LEN        = 32,
   parameter int         DEPTH          = 64,
   parameter int         TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_val,
   input  logic [7:0] rx_data,
   output logic       m_valid,
   output logic [7:0] m_data,
   output logic       m_last,
   input  logic       m_ready,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   parse_state_t  state;
   logic          rx_val_q;
   logic [7:0]    len;
   logic [7:0]    cnt;
   logic [7:0]    chk_acc;
   logic [TW-1:0] tmo_cnt;

   logic   stb;
   logic   tmo_hit;
   logic   len_ok;
   logic   last_byte;
   logic   chk_match;
   logic   full;
   logic   wr_en;
   logic   ovf;
   logic   commit;
   logic   rewind;
   entry_t wr_entry;

   assign stb       = rx_val & ~rx_val_q;
   // A byte landing on the terminal count keeps the frame alive.
   assign tmo_hit   = (state != ST_HUNT) & ~stb & (tmo_cnt == TMO_LAST);
   assign len_ok    = (rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN));
   assign last_byte = (cnt == len - 8'd1);
   assign chk_match = (rx_data == chk_acc);

   always_comb begin
      wr_en         = 1'b0;
      ovf           = 1'b0;
      commit        = 1'b0;
      rewind        = tmo_hit;
      wr_entry.last = last_byte;
      wr_entry.data = rx_data;
      if (stb && state == ST_PAYLOAD) begin
         wr_en = ~full;
         ovf   = full;
      end
      if (stb && state == ST_CHK) begin
         commit = chk_match;
         rewind = ~chk_match;
      end
      if (ovf)
         rewind = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_HUNT;
         rx_val_q  <= 1'b0;
         tmo_cnt   <= '0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= ERR_BAD_LEN;
      end else begin
         rx_val_q  <= rx_val;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         if (state == ST_HUNT || stb || tmo_hit)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + TW'(1);

         if (tmo_hit) begin
            state     <= ST_HUNT;
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
         end else if (stb) begin
            unique case (state)
               ST_HUNT: begin
                  if (rx_data == SYNC_BYTE)
                     state <= ST_LEN;
               end
               ST_LEN: begin
                  if (len_ok) begin
                     len     <= rx_data;
                     chk_acc <= rx_data;
                     cnt     <= 8'd0;
                     state   <= ST_PAYLOAD;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_BAD_LEN;
                     state     <= ST_HUNT;
                  end
               end
               ST_PAYLOAD: begin
                  if (full) begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_OVERFLOW;
                     state     <= ST_HUNT;
                  end else begin
                     chk_acc <= chk_acc ^ rx_data;
                     cnt     <= cnt + 8'd1;
                     if (last_byte)
                        state <= ST_CHK;
                  end
               end
               ST_CHK: begin
                  if (chk_match) begin
                     frame_ok <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_BAD_CHK;
                  end
                  state <= ST_HUNT;
               end
               default: state <= ST_HUNT;
            endcase
         end
      end
   end

   uart_commit_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_entry (wr_entry),
      .commit   (commit),
      .rewind   (rewind),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_last   (m_last),
      .m_ready  (m_ready),
      .full     (full)
   );

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a small FIFO and short timeout to reach the corner cases.
module tb_uart_frame_parser;

   localparam int T = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_val;
   logic [7:0] rx_data;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_last;
   logic       m_ready;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;

   int tests_run    = 0;
   int tests_failed = 0;
   int ok_cnt       = 0;
   int err_cnt      = 0;
   int both_cnt     = 0;
   int last_code    = -1;
   int ready_mode   = 0;
   int rd_idx       = 0;
   int ok0, err0;
   logic [8:0] got_q [$];

   uart_frame_parser #(
      .SYNC_BYTE      (8'h55),
      .MAX_LEN        (4),
      .DEPTH          (4),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_val    (rx_val),
      .rx_data   (rx_data),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_last    (m_last),
      .m_ready   (m_ready),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset) begin
         if (frame_ok) ok_cnt++;
         if (frame_err) begin
            err_cnt++;
            last_code = int'(err_code);
         end
         if (frame_ok && frame_err) both_cnt++;
         if (m_valid && m_ready) got_q.push_back({m_last, m_data});
      end
   end

   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ~m_ready;
         endcase
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold = 1);
      rx_data = b;
      rx_val  = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      rx_val = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send_seq(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_entry(input string tag, input logic [8:0] e);
      if (rd_idx < got_q.size()) check(tag, 32'(got_q[rd_idx]), 32'(e));
      else check(tag, 32'hDEAD, 32'(e));
      rd_idx++;
   endtask

   task automatic mark();
      ok0  = ok_cnt;
      err0 = err_cnt;
   endtask

   initial begin
      reset   = 1'b0;
      rx_val  = 1'b0;
      rx_data = 8'h00;
      settle(3);
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_frame_ok", 32'(frame_ok), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      check("rst_err_code", 32'(err_code), 0);
      reset = 1'b1;
      settle(2);

      // good frame
      ready_mode = 1;
      mark();
      send_seq(64'h55_03_11_22_33_03, 6);
      settle(6);
      check("good_ok", 32'(ok_cnt - ok0), 1);
      check("good_err", 32'(err_cnt - err0), 0);
      expect_entry("good_b0", 9'h011);
      expect_entry("good_b1", 9'h022);
      expect_entry("good_b2", 9'h133);
      check("good_drained", 32'(m_valid), 0);

      // bad checksum, then a good frame
      ready_mode = 0;
      mark();
      send_seq(64'h55_02_AA_BB_00, 5);
      settle(3);
      check("badchk_err", 32'(err_cnt - err0), 1);
      check("badchk_code", 32'(last_code), 1);
      check("badchk_ok", 32'(ok_cnt - ok0), 0);
      check("badchk_m_valid", 32'(m_valid), 0);
      ready_mode = 1;
      mark();
      send_seq(64'h55_02_AA_BB_13, 5);
      settle(6);
      check("after_bad_ok", 32'(ok_cnt - ok0), 1);
      expect_entry("after_bad_b0", 9'h0AA);
      expect_entry("after_bad_b1", 9'h1BB);

      // junk before sync, length limits
      mark();
      send_seq(64'h00_FF_12, 3);
      settle(3);
      check("junk_pulses", 32'(ok_cnt - ok0 + err_cnt - err0), 0);
      send_seq(64'h55_00, 2);
      settle(2);
      check("len0_err", 32'(err_cnt - err0), 1);
      check("len0_code", 32'(last_code), 0);
      send_seq(64'h55_05, 2);
      settle(2);
      check("len_max1_err", 32'(err_cnt - err0), 2);
      check("len_max1_code", 32'(last_code), 0);
      mark();
      send_seq(64'h55_04_01_02_03_04_00, 7);
      settle(8);
      check("len_max_ok", 32'(ok_cnt - ok0), 1);
      expect_entry("len_max_b0", 9'h001);
      expect_entry("len_max_b1", 9'h002);
      expect_entry("len_max_b2", 9'h003);
      expect_entry("len_max_b3", 9'h104);

      // commit latency and overflow with committed data held
      ready_mode = 0;
      settle(2);
      mark();
      send_seq(64'h55_01_7E, 3);
      rx_data = 8'h7F;
      rx_val  = 1'b1;
      @(posedge clk);
      #1;
      check("lat_frame_ok", 32'(frame_ok), 1);
      check("lat_m_valid", 32'(m_valid), 1);
      check("lat_m_head", 32'({m_last, m_data}), 32'h17E);
      rx_val = 1'b0;
      settle(1);
      send_seq(64'h55_04_01_02_03, 5);
      check("ovf_not_yet", 32'(err_cnt - err0), 0);
      send_byte(8'h04);
      settle(1);
      check("ovf_err", 32'(err_cnt - err0), 1);
      check("ovf_code", 32'(last_code), 2);
      send_byte(8'h33);
      settle(2);
      check("ovf_tail_quiet", 32'(err_cnt - err0), 1);
      check("ovf_kept_valid", 32'(m_valid), 1);
      ready_mode = 1;
      settle(4);
      expect_entry("ovf_kept", 9'h17E);
      check("ovf_drained", 32'(m_valid), 0);
      send_seq(64'h55_01_A5_A4, 4);
      settle(4);
      expect_entry("post_ovf", 9'h1A5);

      // timeout
      mark();
      send_seq(64'h55_02_AA, 3);
      repeat (T - 2) @(posedge clk);
      #1;
      check("tmo_early", 32'(frame_err), 0);
      @(posedge clk);
      #1;
      check("tmo_err", 32'(frame_err), 1);
      check("tmo_code", 32'(err_code), 3);
      settle(2);
      send_seq(64'h55_02_AA_BB_13, 5);
      settle(6);
      expect_entry("tmo_next_b0", 9'h0AA);
      expect_entry("tmo_next_b1", 9'h1BB);

      // byte on the terminal cycle wins over the timeout
      mark();
      send_seq(64'h55_02_AA, 3);
      repeat (T - 2) @(posedge clk);
      #1;
      send_byte(8'hBB);
      send_byte(8'h13);
      settle(6);
      check("tmo_edge_err", 32'(err_cnt - err0), 0);
      check("tmo_edge_ok", 32'(ok_cnt - ok0), 1);
      expect_entry("tmo_edge_b0", 9'h0AA);
      expect_entry("tmo_edge_b1", 9'h1BB);

      // back-to-back frames, held rx_val, toggling ready
      ready_mode = 2;
      mark();
      send_byte(8'h55);
      send_byte(8'h02);
      send_byte(8'hC3, 3);
      send_byte(8'h3C);
      send_byte(8'hFD);
      send_byte(8'h55, 2);
      send_byte(8'h01);
      send_byte(8'h5A);
      send_byte(8'h5B);
      settle(10);
      check("b2b_ok", 32'(ok_cnt - ok0), 2);
      check("b2b_err", 32'(err_cnt - err0), 0);
      expect_entry("b2b_b0", 9'h0C3);
      expect_entry("b2b_b1", 9'h13C);
      expect_entry("b2b_b2", 9'h15A);

      // reset mid-payload drops committed and speculative data
      ready_mode = 0;
      settle(2);
      send_seq(64'h55_01_66_67, 4);
      settle(1);
      check("pre_rst_valid", 32'(m_valid), 1);
      send_seq(64'h55_03_11, 3);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_valid", 32'(m_valid), 0);
      reset = 1'b1;
      ready_mode = 1;
      settle(4);
      check("rst_nothing_out", 32'(got_q.size() - rd_idx), 0);
      send_seq(64'h55_01_99_98, 4);
      settle(4);
      expect_entry("post_rst", 9'h199);

      check("never_both", 32'(both_cnt), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
